sram_like_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE/MEM stages).
- Sits between the pipeline and the unified memory/bridge.
- Arbitrates requests, keeps up to MAX_OUT transactions outstanding in order, and routes each response back to its owner.
- Prevents instruction starvation under back-to-back data traffic.

---
 rtl/sram_like_arbiter_pkg.sv | 10 +
 rtl/sram_like_arbiter_id_fifo.sv | 53 +++++
 rtl/sram_like_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_like_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared owner IDs and request-bundle layout for the sram-like port arbiter.
package sram_like_arbiter_pkg;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // wr(1) + size(2) + wstrb(4) + addr(32) + wdata(32)
  localparam int SRAM_LIKE_REQ_WD = 71;

  typedef logic [SRAM_LIKE_REQ_WD-1:0] req_bus_t;
endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order owner-ID FIFO; a push is accepted while full when a pop frees a slot in the same cycle.
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic pop_i,
  input  logic id_i,
  output logic id_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign id_o    = mem_q[rptr_q];

  always_comb begin
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop  ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= id_i;
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates the IF and EXE/MEM sram-like requesters onto one memory port, tracking
// outstanding transactions in order and steering each response to its owner.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          lock_q, lock_d, lock_owner_q, lock_owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic          sel, gnt, can_grant, accept, pop;
  logic          fifo_full, fifo_empty, head_owner;
  req_bus_t      inst_bus, data_bus, mem_bus;

  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
  assign mem_bus  = (sel == OWNER_DATA) ? data_bus : inst_bus;
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bus;

  // A same-cycle response frees a slot, so a full FIFO can still take a new request.
  assign pop       = resetn & mem_data_ok & ~fifo_empty;
  assign can_grant = ~fifo_full | pop;

  always_comb begin
    sel = OWNER_INST;
    gnt = 1'b0;
    if (can_grant) begin
      if (lock_q) begin
        sel = lock_owner_q;
        gnt = (lock_owner_q == OWNER_DATA) ? data_req : inst_req;
      end else if (data_req && !(inst_req && starve_q == SW'(STARVE_LIMIT))) begin
        sel = OWNER_DATA;
        gnt = 1'b1;
      end else if (inst_req) begin
        sel = OWNER_INST;
        gnt = 1'b1;
      end
    end
  end

  assign mem_req      = resetn & gnt;
  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (sel == OWNER_INST);
  assign data_addr_ok = accept & (sel == OWNER_DATA);
  assign inst_data_ok = pop & (head_owner == OWNER_INST);
  assign data_data_ok = pop & (head_owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err          = err_q;

  always_comb begin
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d       = 1'b1;
      lock_owner_d = sel;
    end

    starve_d = starve_q;
    if (!inst_req || (accept && sel == OWNER_INST))
      starve_d = '0;
    else if (accept && sel == OWNER_DATA && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;

    err_d = err_q | (mem_data_ok & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
      starve_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      starve_q     <= starve_d;
      err_q        <= err_d;
    end
  end

  arb_id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .pop_i   (pop),
    .id_i    (sel),
    .id_o    (head_owner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench with an owner scoreboard: expected owners are queued on accept and
// checked against the data_ok steering when responses are driven.
module tb_sram_like_arbiter;
  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;
  localparam logic [31:0] IADDR = 32'h1C00_0000;
  localparam logic [31:0] DADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok, err;

  int   total = 0;
  int   bad   = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect `own` to win this cycle and queue it as the next response owner.
  task automatic exp_acc(input string tag, input logic own, input logic [31:0] addr);
    chk({tag, "_memreq"}, 32'(mem_req), 32'd1);
    chk({tag, "_iaok"}, 32'(inst_addr_ok), 32'(own == INST));
    chk({tag, "_daok"}, 32'(data_addr_ok), 32'(own == DATA));
    chk({tag, "_addr"}, mem_addr, addr);
    if (mem_req && mem_addr_ok) sb_q.push_back(own);
  endtask

  task automatic check_resp(input string tag, input logic [31:0] v);
    logic own;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      own = sb_q.pop_front();
      chk({tag, "_idok"}, 32'(inst_data_ok), 32'(own == INST));
      chk({tag, "_ddok"}, 32'(data_data_ok), 32'(own == DATA));
      chk({tag, "_rdata"}, (own == INST) ? inst_rdata : data_rdata, v);
    end
  endtask

  task automatic respond(input string tag, input logic [31:0] v);
    mem_data_ok = 1'b1;
    mem_rdata   = v;
    #1;
    check_resp(tag, v);
    tick();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = IADDR; inst_wdata = 32'h1111_1111;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'h3;
    data_addr = DADDR; data_wdata = 32'hD0D0_D0D0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;

    // reset with everything asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_memreq", 32'(mem_req), 32'd0);
      chk("rst_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      chk("rst_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end
    resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    tick();
    chk("post_rst_err", 32'(err), 32'd0);

    // conflict: data first, inst next cycle
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    #1;
    exp_acc("conf_d", DATA, DADDR);
    chk("conf_wdata", mem_wdata, 32'hD0D0_D0D0);
    chk("conf_wr", 32'(mem_wr), 32'd1);
    tick();
    data_req = 1'b0;
    #1;
    exp_acc("conf_i", INST, IADDR);
    tick();
    inst_req = 1'b0;
    respond("conf_r1", 32'h1111_0000);
    respond("conf_r2", 32'h2222_0000);

    // lock: inst stalled by memory, data must not steal the port
    inst_req = 1'b1; mem_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) data_req = 1'b1;
      #1;
      chk("lock_memreq", 32'(mem_req), 32'd1);
      chk("lock_addr", mem_addr, IADDR);
      chk("lock_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      tick();
    end
    mem_addr_ok = 1'b1;
    #1;
    exp_acc("lock_i", INST, IADDR);
    tick();
    inst_req = 1'b0;
    #1;
    exp_acc("lock_d", DATA, DADDR);
    tick();
    data_req = 1'b0;
    respond("lock_r1", 32'hCAFE_0001);
    respond("lock_r2", 32'hCAFE_0002);

    // outstanding limit and ordering
    data_req = 1'b1; inst_req = 1'b1;
    #1;
    exp_acc("out_d", DATA, DADDR);
    tick();
    data_req = 1'b0;
    #1;
    exp_acc("out_i", INST, IADDR);
    tick();
    inst_addr = IADDR + 32'h4;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("out_full_memreq", 32'(mem_req), 32'd0);
      chk("out_full_iaok", 32'(inst_addr_ok), 32'd0);
      tick();
    end
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_5555;
    #1;
    check_resp("out_r1", 32'hAAAA_5555);
    exp_acc("out_i2", INST, IADDR + 32'h4);
    tick();
    inst_req = 1'b0; mem_data_ok = 1'b0; data_req = 1'b1;
    #1;
    chk("out_still_full", 32'(mem_req), 32'd0);
    tick();
    data_req = 1'b0;
    respond("out_r2", 32'h1234_5678);
    respond("out_r3", 32'h8765_4321);
    inst_addr = IADDR;

    // starvation: 4 DATA, 1 INST, repeated
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic own;
      own = (i == 4 || i == 9) ? INST : DATA;
      if (i > 0) begin
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5000 + 32'(i);
      end
      #1;
      if (i > 0) check_resp("stv_r", 32'h5000 + 32'(i));
      exp_acc("stv", own, (own == DATA) ? DADDR : IADDR);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    respond("stv_last", 32'h6000_0000);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // protocol violation with empty FIFO
    chk("pre_viol_err", 32'(err), 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("viol_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("viol_err_sticky", 32'(err), 32'd1);
      tick();
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("viol_err_clr", 32'(err), 32'd0);

    // reset mid-transaction discards the outstanding entry
    tick();
    inst_req = 1'b1;
    #1;
    chk("mid_iaok", 32'(inst_addr_ok), 32'd1);
    tick();
    inst_req = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk("mid_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk("mid_err", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
